regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Parametrised multi-port integer register file for the RV32I pipeline: NRD combinational read
//  ports, NWR write ports with fixed priority, optional write-to-read bypass and x0 hardwiring.
//  Adds a per-register busy scoreboard (set at issue, cleared at writeback, bulk-flushed on
//  redirect) so decode can detect RAW hazards. Sits between decode (reads/issue) and writeback.
// PARAMETERS
//  XLEN     32  data width in bits
//  NREGS    32  number of architectural registers (power of 2, >=2); AW = $clog2(NREGS)
//  NRD      2   number of read ports
//  NWR      1   number of write ports (1..4); higher port index has higher priority
//  BYPASS   1   1 = same-cycle write data forwarded to reads; 0 = reads see registered state only
//  ZERO_R0  1   1 = register 0 reads 0, ignores writes, never busy
// PORTS
//  clk        in   1            clock, all state updates on rising edge
//  reset_n    in   1            asynchronous, active-low reset
//  wr_en      in   NWR          per-port write enable
//  wr_addr    in   NWR*AW       per-port destination register
//  wr_data    in   NWR*XLEN     per-port write data
//  rd_addr    in   NRD*AW       per-port source register
//  rd_data    out  NRD*XLEN     per-port read data (combinational)
//  rd_busy    out  NRD          1 = source register has an outstanding producer
//  issue_en   in   1            instruction issued that will write issue_rd
//  issue_rd   in   AW           destination of issued instruction
//  flush      in   1            pipeline redirect: clear every busy bit
//  busy_vec   out  NREGS        raw scoreboard state (debug/verification)
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (clk, reset_n). While reset_n=0 all
//   registers = 0 and all busy bits = 0, so rd_data = 0 and rd_busy = 0 for every port.
//  Write: at posedge, for each register, the highest-index port k with wr_en[k] and
//   wr_addr[k]==reg commits wr_data[k]; lower-index hits to the same reg are dropped. Latency 1.
//  ZERO_R0=1: writes to reg 0 discarded; rd_addr==0 returns 0 (even with bypass); busy[0] stays 0.
//  Read: rd_data[p] = regs[rd_addr[p]] combinationally. If BYPASS=1 and any wr_en[k] targets
//   rd_addr[p] (non-zero when ZERO_R0), rd_data[p] = wr_data of the highest-priority such port.
//  Scoreboard next-state per reg r, priority high->low:
//   1) flush=1 -> busy[r]=0 (data writes in the same cycle still commit).
//   2) issue_en && issue_rd==r -> busy[r]=1 (new producer wins over a same-cycle writeback).
//   3) any wr_en[k] && wr_addr[k]==r -> busy[r]=0.
//   4) otherwise hold.
//  rd_busy[p] = busy[rd_addr[p]], except BYPASS=1 and a same-cycle write to rd_addr[p] -> 0
//   (value available via bypass). A same-cycle issue never affects rd_busy until next cycle.
//  Scoreboard is a single bit per reg: a second issue to a busy reg keeps it busy; the first
//   writeback clears it. Decode must not issue a WAW over an outstanding producer.
//  Reset asserted mid-operation: immediate clear of regs and busy; no pending write survives.
//  All outputs are free of X when all inputs are known; out-of-range addresses impossible.
// STRUCTURE
//  Package rv_rf_pkg: XLEN, NREGS, AW localparam, typedefs reg_addr_t, xlen_t, busy_vec_t.
//  Sub-module rf_scoreboard (busy bits, flush/issue/clear priority, rd_busy masking); data array
//   and write-priority/bypass muxes stay in the top. Priority resolved by for-loop, last wins.
// TESTING
//  Reset: drive writes, assert reset_n=0 async mid-cycle -> all rd_data=0, busy_vec=0 at once.
//  Write/read: wr x5=32'hDEADBEEF, next cycle rd_addr0=5 -> rd_data0=32'hDEADBEEF, latency 1.
//  Bypass: same cycle wr x7=32'h1234 and rd_addr1=7 -> rd_data1=32'h1234 (BYPASS=1), old val (0).
//  Priority (NWR=2): port0 x3=32'hA, port1 x3=32'hB -> x3 reads 32'hB next cycle.
//  x0: wr x0=32'hFFFF_FFFF, issue_rd=0 -> rd_data=0, busy_vec[0]=0.
//  Scoreboard: issue x9 -> rd_busy=1; issue x9 + wb x9 same cycle -> stays 1; flush -> 0.

Source files
------------

// File: rtl/rv_rf_pkg.sv
// Shared constants and types for the RV32I integer register file and its scoreboard.
package rv_rf_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [XLEN-1:0]  xlen_t;
    typedef logic [NREGS-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// Decode/writeback-facing bus of the multi-port register file.
//   master : decode + writeback side (drives writes, reads, issue, flush)
//   slave  : register file (returns read data, busy flags, raw busy vector)
interface regfile_mp_scoreboard_if
    import rv_rf_pkg::*;
#(
    parameter int unsigned NRD = 2,
    parameter int unsigned NWR = 1
);

    logic      [NWR-1:0] wr_en;
    reg_addr_t [NWR-1:0] wr_addr;
    xlen_t     [NWR-1:0] wr_data;
    reg_addr_t [NRD-1:0] rd_addr;
    xlen_t     [NRD-1:0] rd_data;
    logic      [NRD-1:0] rd_busy;
    logic                issue_en;
    reg_addr_t           issue_rd;
    logic                flush;
    busy_vec_t           busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_rd, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_rd, flush,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, bulk-cleared on flush.
// Ports: clk, reset_n, write port enables/addresses, read addresses, issue_en/issue_rd,
//        flush -> rd_busy (combinational per read port), busy_vec (registered state).
module rf_scoreboard
    import rv_rf_pkg::*;
#(
    parameter int unsigned NRD     = 2,
    parameter int unsigned NWR     = 1,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic      [NWR-1:0] wr_en,
    input  reg_addr_t [NWR-1:0] wr_addr,
    input  reg_addr_t [NRD-1:0] rd_addr,
    input  logic                issue_en,
    input  reg_addr_t           issue_rd,
    input  logic                flush,
    output logic      [NRD-1:0] rd_busy,
    output busy_vec_t           busy_vec
);

    busy_vec_t busy_q;
    busy_vec_t busy_d;
    logic      wb_hit;
    logic      rd_hit;

    // Next state: flush beats issue, issue beats a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        wb_hit = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            wb_hit = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] == reg_addr_t'(r))) begin
                    wb_hit = 1'b1;
                end
            end
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (issue_en && (issue_rd == reg_addr_t'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wb_hit) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A same-cycle write to the source means its value is already forwarded.
    always_comb begin
        rd_busy = '0;
        rd_hit  = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            rd_hit = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] == rd_addr[p])) begin
                    rd_hit = 1'b1;
                end
            end
            rd_busy[p] = busy_q[rd_addr[p]];
            if ((BYPASS && rd_hit) || !reset_n) begin
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port RV32I integer register file with fixed-priority writes, optional
// write-to-read bypass, optional x0 hardwiring and a RAW-hazard busy scoreboard.
// Ports: clk, reset_n (async, active-low), bus (slave modport: writes, reads,
//        issue/flush in; rd_data, rd_busy combinational, busy_vec registered out).
module regfile_mp_scoreboard
    import rv_rf_pkg::*;
#(
    parameter int unsigned NRD     = 2,
    parameter int unsigned NWR     = 1,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    regfile_mp_scoreboard_if.slave  bus
);

    xlen_t [NREGS-1:0] regs_q;
    xlen_t [NREGS-1:0] regs_d;
    xlen_t [NRD-1:0]   rd_data_c;

    // Write commit: higher port index overrides lower on the same register.
    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NREGS; r++) begin
            for (int k = 0; k < NWR; k++) begin
                if (bus.wr_en[k] && (bus.wr_addr[k] == reg_addr_t'(r))) begin
                    regs_d[r] = bus.wr_data[k];
                end
            end
        end
        if (ZERO_R0) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read mux with forwarding; x0 and reset force zero even when a write is forwarded.
    always_comb begin
        rd_data_c = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data_c[p] = regs_q[bus.rd_addr[p]];
            if (BYPASS) begin
                for (int k = 0; k < NWR; k++) begin
                    if (bus.wr_en[k] && (bus.wr_addr[k] == bus.rd_addr[p])) begin
                        rd_data_c[p] = bus.wr_data[k];
                    end
                end
            end
            if ((ZERO_R0 && (bus.rd_addr[p] == '0)) || !reset_n) begin
                rd_data_c[p] = '0;
            end
        end
    end

    assign bus.rd_data = rd_data_c;

    rf_scoreboard #(
        .NRD     (NRD),
        .NWR     (NWR),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rd_addr  (bus.rd_addr),
        .issue_en (bus.issue_en),
        .issue_rd (bus.issue_rd),
        .flush    (bus.flush),
        .rd_busy  (bus.rd_busy),
        .busy_vec (bus.busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard (NRD=2, NWR=2, BYPASS=1, ZERO_R0=1).
module tb_regfile_mp_scoreboard;
    import rv_rf_pkg::*;

    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;
    localparam int          NVEC = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    regfile_mp_scoreboard_if #(.NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp_scoreboard #(
        .NRD(NRD), .NWR(NWR), .BYPASS(1'b1), .ZERO_R0(1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic      we0;  reg_addr_t wa0; xlen_t wd0;
        logic      we1;  reg_addr_t wa1; xlen_t wd1;
        reg_addr_t ra0;  reg_addr_t ra1;
        logic      ie;   reg_addr_t ird; logic  fl;
        xlen_t     e_rd0; xlen_t e_rd1; logic [1:0] e_busy; busy_vec_t e_vec;
    } vec_t;

    typedef struct {
        xlen_t      rd0;
        xlen_t      rd1;
        logic [1:0] busy;
    } exp_t;

    vec_t      vecs [NVEC];
    exp_t      comb_q [$];
    busy_vec_t vec_q [$];
    int        n_checks = 0;
    int        n_pass   = 0;

    function automatic vec_t mk(logic we0, reg_addr_t wa0, xlen_t wd0,
                                logic we1, reg_addr_t wa1, xlen_t wd1,
                                reg_addr_t ra0, reg_addr_t ra1,
                                logic ie, reg_addr_t ird, logic fl,
                                xlen_t e_rd0, xlen_t e_rd1, logic [1:0] e_busy,
                                busy_vec_t e_vec);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1;
        v.ie = ie; v.ird = ird; v.fl = fl;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy = e_busy; v.e_vec = e_vec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.wr_en      = {v.we1, v.we0};
        bus.wr_addr[0] = v.wa0;
        bus.wr_addr[1] = v.wa1;
        bus.wr_data[0] = v.wd0;
        bus.wr_data[1] = v.wd1;
        bus.rd_addr[0] = v.ra0;
        bus.rd_addr[1] = v.ra1;
        bus.issue_en   = v.ie;
        bus.issue_rd   = v.ird;
        bus.flush      = v.fl;
    endtask

    task automatic idle();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.issue_en = 1'b0;
        bus.issue_rd = '0;
        bus.flush    = 1'b0;
    endtask

    initial begin
        exp_t      e;
        busy_vec_t bv;

        //          we0 wa0 wd0           we1 wa1 wd1           ra0 ra1 ie ird fl  rd0           rd1           busy   busy_vec after edge
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,              1, 2,  0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0);
        vecs[1]  = mk(0, 0, 0,            0, 0, 0,              5, 0,  0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0);
        vecs[2]  = mk(0, 0, 0,            1, 7, 32'h1234,       5, 7,  0, 0, 0, 32'hDEADBEEF, 32'h1234,     2'b00, 32'h0);
        vecs[3]  = mk(1, 3, 32'hA,        1, 3, 32'hB,          3, 7,  0, 0, 0, 32'hB,        32'h1234,     2'b00, 32'h0);
        vecs[4]  = mk(0, 0, 0,            0, 0, 0,              3, 3,  0, 0, 0, 32'hB,        32'hB,        2'b00, 32'h0);
        vecs[5]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF,   0, 0,  1, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0);
        vecs[6]  = mk(0, 0, 0,            0, 0, 0,              0, 9,  1, 9, 0, 32'h0,        32'h0,        2'b00, 32'h0000_0200);
        vecs[7]  = mk(0, 0, 0,            0, 0, 0,              9, 5,  0, 0, 0, 32'h0,        32'hDEADBEEF, 2'b01, 32'h0000_0200);
        vecs[8]  = mk(1, 9, 32'h99,       0, 0, 0,              9, 3,  1, 9, 0, 32'h99,       32'hB,        2'b00, 32'h0000_0200);
        vecs[9]  = mk(0, 0, 0,            0, 0, 0,              9, 9,  1, 12, 0, 32'h99,      32'h99,       2'b11, 32'h0000_1200);
        vecs[10] = mk(0, 0, 0,            1, 12, 32'hC0FFEE,    12, 9, 0, 0, 1, 32'hC0FFEE,   32'h99,       2'b10, 32'h0);
        vecs[11] = mk(0, 0, 0,            0, 0, 0,              12, 9, 1, 4, 1, 32'hC0FFEE,   32'h99,       2'b00, 32'h0);
        vecs[12] = mk(0, 0, 0,            0, 0, 0,              4, 12, 1, 4, 0, 32'h0,        32'hC0FFEE,   2'b00, 32'h0000_0010);
        vecs[13] = mk(0, 0, 0,            0, 0, 0,              4, 0,  1, 4, 0, 32'h0,        32'h0,        2'b01, 32'h0000_0010);
        vecs[14] = mk(1, 4, 32'h44,       0, 0, 0,              4, 4,  0, 0, 0, 32'h44,       32'h44,       2'b00, 32'h0);
        vecs[15] = mk(0, 0, 0,            0, 0, 0,              4, 12, 0, 0, 0, 32'h44,       32'hC0FFEE,   2'b00, 32'h0);

        // Power-on reset
        reset_n = 1'b0;
        idle();
        bus.rd_addr[0] = 5'd5;
        bus.rd_addr[1] = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_data0", bus.rd_data[0], 32'h0);
        check("reset rd_data1", bus.rd_data[1], 32'h0);
        check("reset rd_busy", 32'(bus.rd_busy), 32'h0);
        check("reset busy_vec", bus.busy_vec, 32'h0);
        reset_n = 1'b1;

        // Table-driven vectors with a scoreboard queue of expected outputs
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            if (vec_q.size() > 0) begin
                bv = vec_q.pop_front();
                check($sformatf("v%0d busy_vec", i - 1), bus.busy_vec, bv);
            end
            apply(vecs[i]);
            comb_q.push_back('{vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_busy});
            vec_q.push_back(vecs[i].e_vec);
            #3;
            e = comb_q.pop_front();
            check($sformatf("v%0d rd_data0", i), bus.rd_data[0], e.rd0);
            check($sformatf("v%0d rd_data1", i), bus.rd_data[1], e.rd1);
            check($sformatf("v%0d rd_busy", i), 32'(bus.rd_busy), 32'(e.busy));
        end
        @(posedge clk);
        #1;
        idle();
        bv = vec_q.pop_front();
        check("v15 busy_vec", bus.busy_vec, bv);

        // Asynchronous reset in the middle of activity
        bus.issue_en   = 1'b1;
        bus.issue_rd   = 5'd21;
        bus.wr_en      = 2'b01;
        bus.wr_addr[0] = 5'd20;
        bus.wr_data[0] = 32'h55;
        bus.rd_addr[0] = 5'd5;
        bus.rd_addr[1] = 5'd20;
        @(posedge clk);
        #1;
        check("pre-reset busy_vec", bus.busy_vec, 32'h0020_0000);
        check("pre-reset rd_data1", bus.rd_data[1], 32'h55);
        bus.issue_en   = 1'b0;
        bus.wr_en      = 2'b10;
        bus.wr_addr[0] = 5'd0;
        bus.wr_addr[1] = 5'd22;
        bus.wr_data[1] = 32'h66;
        bus.rd_addr[1] = 5'd22;
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset rd_data0", bus.rd_data[0], 32'h0);
        check("async reset bypass rd_data1", bus.rd_data[1], 32'h0);
        check("async reset busy_vec", bus.busy_vec, 32'h0);
        check("async reset rd_busy", 32'(bus.rd_busy), 32'h0);
        @(posedge clk);
        #1;
        idle();
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_addr[0] = 5'd20;
        bus.rd_addr[1] = 5'd22;
        #1;
        check("post-reset x20", bus.rd_data[0], 32'h0);
        check("post-reset x22", bus.rd_data[1], 32'h0);
        check("post-reset busy_vec", bus.busy_vec, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
